cook_countdown: RTL and testbench

COOK_COUNTDOWN -- requirements
Module: cook_countdown

---
 rtl/eggtimer_pkg.sv | 23 ++
 rtl/rise_detect.sv | 25 ++
 rtl/cook_countdown.sv | 174 +++++++++++++++++
 tb/tb_cook_countdown.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/eggtimer_pkg.sv
// Shared definitions for the egg-timer datapath: controller state encoding,
// BCD digit limits and the preset clamp helper.
package eggtimer_pkg;

  // Controller states of the countdown.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest legal value of each displayed digit (mm:ss style seconds, 0..59).
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  // Limit a digit to its legal maximum so a corrupted preset can never
  // produce an out-of-range BCD count.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge detector for an already-debounced level input.
// History clears to 0 on reset, so an input held high across reset release
// reports an edge on the first cycle after reset.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic hist_reg;

  // Remember the previous sample of the input.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_reg <= 1'b0;
    end else begin
      hist_reg <= in;
    end
  end

  // Pulse acts in the same cycle the new high level is seen.
  assign pulse = in & ~hist_reg;

endmodule

// File: rtl/cook_countdown.sv
// Kitchen-timer countdown controller: holds a two-digit BCD seconds count,
// decrements it once per second while running, and drives a buzzer for a
// fixed number of seconds after the count expires.
module cook_countdown
  import eggtimer_pkg::*;
#(
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       start_stop,
  input  logic       load,
  input  logic [3:0] preset_ones,
  input  logic [3:0] preset_tens,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  // Alarm counter needs to reach ALARM_TICKS; keep at least one bit so the
  // zero-tick configuration still elaborates cleanly.
  localparam int ACW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [ACW-1:0] ALARM_LIMIT = ACW'(ALARM_TICKS);
  localparam logic ALARM_ON_ENTRY = (ALARM_TICKS != 0);

  state_t           state_reg;
  logic [3:0]       ones_reg;
  logic [3:0]       tens_reg;
  logic             running_reg;
  logic             done_reg;
  logic             alarm_reg;
  logic [ACW-1:0]   alarm_cnt_reg;

  logic             start_ev;
  logic [3:0]       load_ones;
  logic [3:0]       load_tens;
  logic [3:0]       dec_ones;
  logic [3:0]       dec_tens;
  logic             count_zero;
  logic             dec_zero;
  logic [ACW-1:0]   alarm_cnt_next;
  logic             alarm_sat;

  rise_detect u_start_edge (
    .clk   (clk),
    .reset (reset),
    .in    (start_stop),
    .pulse (start_ev)
  );

  // Preset clamp, one-second BCD decrement with borrow, and alarm count step.
  always_comb begin
    load_ones = clamp_digit(preset_ones, ONES_MAX);
    load_tens = clamp_digit(preset_tens, TENS_MAX);

    count_zero = (ones_reg == 4'd0) && (tens_reg == 4'd0);

    dec_ones = ones_reg;
    dec_tens = tens_reg;
    if (!count_zero) begin
      if (ones_reg == 4'd0) begin
        dec_ones = ONES_MAX;
        dec_tens = tens_reg - 4'd1;
      end else begin
        dec_ones = ones_reg - 4'd1;
      end
    end
    dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0);

    alarm_sat      = (alarm_cnt_reg == ALARM_LIMIT);
    alarm_cnt_next = alarm_sat ? alarm_cnt_reg : (alarm_cnt_reg + ACW'(1));
  end

  // Controller FSM: state, count digits and all status outputs are registered
  // together so nothing reaches the outputs combinationally from the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ones_reg      <= 4'd0;
      tens_reg      <= 4'd0;
      running_reg   <= 1'b0;
      done_reg      <= 1'b0;
      alarm_reg     <= 1'b0;
      alarm_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Load beats a simultaneous start; an empty count cannot start.
          if (load) begin
            ones_reg <= load_ones;
            tens_reg <= load_tens;
          end else if (start_ev && !count_zero) begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        end

        ST_RUN: begin
          // Load is ignored while counting.
          if (tick_1hz) begin
            if (count_zero || dec_zero) begin
              // Expiry wins over a start press in the same cycle.
              ones_reg      <= 4'd0;
              tens_reg      <= 4'd0;
              state_reg     <= ST_DONE;
              running_reg   <= 1'b0;
              done_reg      <= 1'b1;
              alarm_reg     <= ALARM_ON_ENTRY;
              alarm_cnt_reg <= '0;
            end else begin
              ones_reg <= dec_ones;
              tens_reg <= dec_tens;
              if (start_ev) begin
                state_reg   <= ST_PAUSE;
                running_reg <= 1'b0;
              end
            end
          end else if (start_ev) begin
            state_reg   <= ST_PAUSE;
            running_reg <= 1'b0;
          end
        end

        ST_PAUSE: begin
          // Count frozen; a new preset abandons the paused run.
          if (load) begin
            ones_reg  <= load_ones;
            tens_reg  <= load_tens;
            state_reg <= ST_IDLE;
          end else if (start_ev) begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        end

        ST_DONE: begin
          if (load || start_ev) begin
            state_reg     <= ST_IDLE;
            done_reg      <= 1'b0;
            alarm_reg     <= 1'b0;
            alarm_cnt_reg <= '0;
            if (load) begin
              ones_reg <= load_ones;
              tens_reg <= load_tens;
            end
          end else if (tick_1hz) begin
            // Count buzzer seconds, saturating once the limit is reached.
            alarm_cnt_reg <= alarm_cnt_next;
            if (alarm_cnt_next == ALARM_LIMIT) begin
              alarm_reg <= 1'b0;
            end
          end
        end

        default: begin
          state_reg   <= ST_IDLE;
          running_reg <= 1'b0;
          done_reg    <= 1'b0;
          alarm_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign ones    = ones_reg;
  assign tens    = tens_reg;
  assign running = running_reg;
  assign done    = done_reg;
  assign alarm   = alarm_reg;

endmodule

// File: tb/tb_cook_countdown.sv
// Directed testbench for cook_countdown: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_cook_countdown;

  logic       clk;
  logic       reset;
  logic       tick_1hz;
  logic       start_stop;
  logic       load;
  logic [3:0] preset_ones;
  logic [3:0] preset_tens;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       running;
  logic       done;
  logic       alarm;

  int total;
  int passes;
  int fails;

  cook_countdown #(.ALARM_TICKS(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .start_stop  (start_stop),
    .load        (load),
    .preset_ones (preset_ones),
    .preset_tens (preset_tens),
    .ones        (ones),
    .tens        (tens),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
      $display("ok   %s = %0h", tag, obs);
    end else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [7:0] cnt, input logic r, input logic d, input logic a);
    chk({tag, ".count"},   {tens, ones}, cnt);
    chk({tag, ".running"}, {7'd0, running}, {7'd0, r});
    chk({tag, ".done"},    {7'd0, done}, {7'd0, d});
    chk({tag, ".alarm"},   {7'd0, alarm}, {7'd0, a});
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    preset_tens = t;
    preset_ones = o;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  // Press and release: the edge acts on the first edge, the release cycle
  // returns the detector history to 0.
  task automatic press();
    start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
    cyc();
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  initial begin
    total = 0;
    passes = 0;
    fails = 0;
    reset = 1'b1;
    tick_1hz = 1'b0;
    start_stop = 1'b0;
    load = 1'b0;
    preset_ones = 4'd0;
    preset_tens = 4'd0;

    // Reset state.
    cyc();
    cyc();
    reset = 1'b0;
    chk_status("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // 25 s full countdown.
    do_load(4'd2, 4'd5);
    chk_status("load25", 8'h25, 1'b0, 1'b0, 1'b0);
    press();
    chk_status("start25", 8'h25, 1'b1, 1'b0, 1'b0);
    for (int n = 24; n >= 0; n--) begin
      tick();
      chk("cd25.count", {tens, ones}, bcd(n));
    end
    chk_status("expire25", 8'h00, 1'b0, 1'b1, 1'b1);

    // Alarm lasts exactly 5 ticks, then saturates; done persists.
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_status("alarm_hold", 8'h00, 1'b0, 1'b1, 1'b1);
    end
    tick();
    chk_status("alarm_off", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk_status("alarm_sat", 8'h00, 1'b0, 1'b1, 1'b0);
    press();
    chk_status("done_exit", 8'h00, 1'b0, 1'b0, 1'b0);

    // Clamp of out-of-range preset digits.
    do_load(4'd7, 4'd12);
    chk_status("clamp", 8'h59, 1'b0, 1'b0, 1'b0);

    // Start with an empty count stays idle.
    do_load(4'd0, 4'd0);
    press();
    chk_status("start_zero", 8'h00, 1'b0, 1'b0, 1'b0);

    // 10 s with a pause in the middle.
    do_load(4'd1, 4'd0);
    press();
    for (int n = 9; n >= 7; n--) begin
      tick();
      chk("run10.count", {tens, ones}, bcd(n));
    end
    press();
    chk_status("pause", 8'h07, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("paused.count", {tens, ones}, 8'h07);
    end
    press();
    chk_status("resume", 8'h07, 1'b1, 1'b0, 1'b0);
    for (int n = 6; n >= 0; n--) begin
      tick();
      chk("run7.count", {tens, ones}, bcd(n));
    end
    chk_status("expire10", 8'h00, 1'b0, 1'b1, 1'b1);

    // Load exits DONE and captures the preset.
    do_load(4'd0, 4'd1);
    chk_status("done_load", 8'h01, 1'b0, 1'b0, 1'b0);

    // Tick and start together at 01: expiry beats pause.
    press();
    chk_status("start01", 8'h01, 1'b1, 1'b0, 1'b0);
    tick_1hz = 1'b1;
    start_stop = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    start_stop = 1'b0;
    chk_status("tick_start", 8'h00, 1'b0, 1'b1, 1'b1);
    cyc();
    press();
    chk_status("exit2", 8'h00, 1'b0, 1'b0, 1'b0);

    // Load ignored in RUN, then reset mid-run at 33.
    do_load(4'd3, 4'd3);
    press();
    do_load(4'd1, 4'd1);
    chk_status("run_load_ign", 8'h33, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick_1hz = 1'b1;
    start_stop = 1'b1;
    cyc();
    reset = 1'b0;
    tick_1hz = 1'b0;
    start_stop = 1'b0;
    chk_status("reset_run", 8'h00, 1'b0, 1'b0, 1'b0);

    // Paused run abandoned by load returns to idle.
    do_load(4'd0, 4'd5);
    press();
    tick();
    press();
    chk_status("pause2", 8'h04, 1'b0, 1'b0, 1'b0);
    do_load(4'd4, 4'd2);
    tick();
    chk_status("pause_load", 8'h42, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
